lp805x_xbus_arb: RTL and testbench

//  Two-master round-robin Wishbone arbiter sharing one external ROM/XRAM slave port of the lp805x.

---
 rtl/lp805x_xbus_arb.sv | 137 +++++++++++++
 tb/tb_lp805x_xbus_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lp805x_xbus_arb.sv
// lp805x_xbus_arb: two-master round-robin Wishbone arbiter in front of the
// shared external ROM/XRAM slave port. Master 0 = core external bus,
// master 1 = secondary requester (DMA / debug loader).
// Optional bus timeout enabled by defining LP805X_XBUS_TMO_EN.
module lp805x_xbus_arb #(
  parameter int AW      = 16,
  parameter int TMO_CYC = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [1:0]      m_cyc_i,
  input  logic [1:0]      m_stb_i,
  input  logic [1:0]      m_we_i,
  input  logic [2*AW-1:0] m_adr_i,
  input  logic [15:0]     m_dat_i,
  output logic [7:0]      m_dat_o,
  output logic [1:0]      m_ack_o,
  output logic [1:0]      m_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [7:0]      s_dat_o,
  input  logic [7:0]      s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state, state_n;
  logic       last;   // last granted master; the other one wins a tie
  logic [1:0] req;    // requests eligible for arbitration
  logic       tmo;    // owner's stalled access hit the timeout limit

  // Marker block only elaborates for an out-of-range timeout setting.
  if (TMO_CYC < 1 || TMO_CYC > 65535) begin : g_tmo_cyc_out_of_range
  end

`ifdef LP805X_XBUS_TMO_EN
  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);

  logic [15:0] cnt;
  logic [1:0]  blk;   // timed-out master locked out until it drops cyc
  logic [1:0]  err;

  assign tmo     = (state != IDLE) && s_stb_o && !s_ack_i && (cnt == TMO_LIM);
  assign req     = m_cyc_i & ~blk;
  assign m_err_o = err;

  // Stall counter: restarts on any grant change or slave ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                            cnt <= '0;
    else if (state_n != state || s_ack_i)    cnt <= '0;
    else if (s_stb_o)                        cnt <= cnt + 16'd1;
  end

  // Error pulse to the timed-out owner, plus its re-arbitration lockout.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err <= 2'b00;
      blk <= 2'b00;
    end else begin
      err <= {tmo && state == OWN1, tmo && state == OWN0};
      for (int n = 0; n < 2; n++) begin
        if (tmo && state == ((n == 0) ? OWN0 : OWN1)) blk[n] <= 1'b1;
        else if (!m_cyc_i[n])                          blk[n] <= 1'b0;
      end
    end
  end
`else
  assign tmo     = 1'b0;
  assign req     = m_cyc_i;
  assign m_err_o = 2'b00;
`endif

  // Grant state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  // Round-robin memory: updated whenever a new owner is granted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                              last <= 1'b1;
    else if (state_n == OWN0 && state != OWN0) last <= 1'b0;
    else if (state_n == OWN1 && state != OWN1) last <= 1'b1;
  end

  // Next owner: release hands straight to a waiting master, no idle gap.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req == 2'b11) state_n = last ? OWN0 : OWN1;
        else if (req[0])  state_n = OWN0;
        else if (req[1])  state_n = OWN1;
      end
      OWN0: if (!m_cyc_i[0] || tmo) state_n = req[1] ? OWN1 : IDLE;
      OWN1: if (!m_cyc_i[1] || tmo) state_n = req[0] ? OWN0 : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Slave-side mux from the owner; ack only reaches an owner still in cycle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = 2'b00;
    case (state)
      OWN0: begin
        s_cyc_o    = m_cyc_i[0];
        s_stb_o    = m_stb_i[0] & m_cyc_i[0];
        s_we_o     = m_we_i[0];
        s_adr_o    = m_adr_i[AW-1:0];
        s_dat_o    = m_dat_i[7:0];
        m_ack_o[0] = s_ack_i & m_cyc_i[0];
      end
      OWN1: begin
        s_cyc_o    = m_cyc_i[1];
        s_stb_o    = m_stb_i[1] & m_cyc_i[1];
        s_we_o     = m_we_i[1];
        s_adr_o    = m_adr_i[2*AW-1:AW];
        s_dat_o    = m_dat_i[15:8];
        m_ack_o[1] = s_ack_i & m_cyc_i[1];
      end
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_lp805x_xbus_arb.sv
// Bench for lp805x_xbus_arb: cycle-by-cycle vector table plus hand-written
// reset-mid-transfer and bus-timeout sequences.
module tb_lp805x_xbus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr;
  logic [15:0] wdat;
  logic [7:0]  mdat, sdat_o, sdat_i;
  logic [1:0]  mack, merr, gnt;
  logic        scyc, sstb, swe, sack;
  logic [15:0] sadr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lp805x_xbus_arb #(.AW(16), .TMO_CYC(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(adr), .m_dat_i(wdat),
    .m_dat_o(mdat), .m_ack_o(mack), .m_err_o(merr),
    .s_cyc_o(scyc), .s_stb_o(sstb), .s_we_o(swe), .s_adr_o(sadr), .s_dat_o(sdat_o),
    .s_dat_i(sdat_i), .s_ack_i(sack), .gnt_o(gnt)
  );

  typedef struct {
    logic [1:0]  cyc, stb, we;
    logic [15:0] a0, a1;
    logic [7:0]  d0, d1;
    logic        ack;
    logic [7:0]  sd;
    logic [1:0]  e_gnt;
    logic        e_cyc, e_stb, e_we;
    logic [15:0] e_adr;
    logic [7:0]  e_dat;
    logic [1:0]  e_ack;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic a);
    cyc = c; stb = s; sack = a;
  endtask

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0;
    sdat_i = '0; sack = 1'b0;

    // reset for two clocks
    tick; tick;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_scyc", 32'(scyc), 32'h0);
    chk("rst_sstb", 32'(sstb), 32'h0);
    chk("rst_ack", 32'(mack), 32'h0);
    chk("rst_err", 32'(merr), 32'h0);
    chk("rst_sadr", 32'(sadr), 32'h0);
    rst = 1'b0;

    //           cyc    stb    we     a0        a1        d0     d1     ack   sd     | gnt   cyc   stb   we    adr       dat    ack
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    // simultaneous request, m0 first then handoff to m1
    vq.push_back('{2'b11,2'b11,2'b00,16'h0010,16'h0020,8'h00,8'h00,1'b0,8'h11, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    vq.push_back('{2'b11,2'b11,2'b00,16'h0010,16'h0020,8'h00,8'h00,1'b1,8'h22, 2'b01,1'b1,1'b1,1'b0,16'h0010,8'h00,2'b01});
    vq.push_back('{2'b10,2'b10,2'b00,16'h0010,16'h0020,8'h00,8'h00,1'b0,8'h33, 2'b01,1'b0,1'b0,1'b0,16'h0010,8'h00,2'b00});
    vq.push_back('{2'b10,2'b10,2'b00,16'h0010,16'h0020,8'h00,8'h00,1'b1,8'h44, 2'b10,1'b1,1'b1,1'b0,16'h0020,8'h00,2'b10});
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b10,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    // m0 read 0x1234, ack on second granted clock with A5, stray acks after release
    vq.push_back('{2'b01,2'b01,2'b00,16'h1234,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    vq.push_back('{2'b01,2'b01,2'b00,16'h1234,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b01,1'b1,1'b1,1'b0,16'h1234,8'h00,2'b00});
    vq.push_back('{2'b01,2'b01,2'b00,16'h1234,16'h0000,8'h00,8'h00,1'b1,8'hA5, 2'b01,1'b1,1'b1,1'b0,16'h1234,8'h00,2'b01});
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b1,8'h5C, 2'b01,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b1,8'hC3, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    // simultaneous request again: m0 owned last, so m1 first
    vq.push_back('{2'b11,2'b11,2'b00,16'h0030,16'h0040,8'h00,8'h00,1'b0,8'h00, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    vq.push_back('{2'b11,2'b11,2'b00,16'h0030,16'h0040,8'h00,8'h00,1'b1,8'h66, 2'b10,1'b1,1'b1,1'b0,16'h0040,8'h00,2'b10});
    vq.push_back('{2'b01,2'b01,2'b00,16'h0030,16'h0040,8'h00,8'h00,1'b0,8'h00, 2'b10,1'b0,1'b0,1'b0,16'h0040,8'h00,2'b00});
    vq.push_back('{2'b01,2'b01,2'b00,16'h0030,16'h0040,8'h00,8'h00,1'b1,8'h77, 2'b01,1'b1,1'b1,1'b0,16'h0030,8'h00,2'b01});
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b01,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    // m1 writes 0x00FF<=5A, m0 requests mid-cycle and stalls
    vq.push_back('{2'b10,2'b10,2'b10,16'h0000,16'h00FF,8'h00,8'h5A,1'b0,8'h00, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    vq.push_back('{2'b11,2'b11,2'b10,16'h1111,16'h00FF,8'h33,8'h5A,1'b0,8'h00, 2'b10,1'b1,1'b1,1'b1,16'h00FF,8'h5A,2'b00});
    vq.push_back('{2'b11,2'b11,2'b10,16'h1111,16'h00FF,8'h33,8'h5A,1'b1,8'h88, 2'b10,1'b1,1'b1,1'b1,16'h00FF,8'h5A,2'b10});
    vq.push_back('{2'b11,2'b01,2'b10,16'h1111,16'h00FF,8'h33,8'h5A,1'b0,8'h00, 2'b10,1'b1,1'b0,1'b1,16'h00FF,8'h5A,2'b00});
    vq.push_back('{2'b01,2'b01,2'b00,16'h1111,16'h00FF,8'h33,8'h5A,1'b0,8'h00, 2'b10,1'b0,1'b0,1'b0,16'h00FF,8'h5A,2'b00});
    vq.push_back('{2'b01,2'b01,2'b00,16'h1111,16'h00FF,8'h33,8'h5A,1'b1,8'h99, 2'b01,1'b1,1'b1,1'b0,16'h1111,8'h33,2'b01});
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b01,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});
    vq.push_back('{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00,1'b0,8'h00, 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00,2'b00});

    for (int i = 0; i < vq.size(); i++) begin
      cyc = vq[i].cyc; stb = vq[i].stb; we = vq[i].we;
      adr = {vq[i].a1, vq[i].a0}; wdat = {vq[i].d1, vq[i].d0};
      sack = vq[i].ack; sdat_i = vq[i].sd;
      #1;
      chk($sformatf("v%0d_gnt", i),  32'(gnt),    32'(vq[i].e_gnt));
      chk($sformatf("v%0d_scyc", i), 32'(scyc),   32'(vq[i].e_cyc));
      chk($sformatf("v%0d_sstb", i), 32'(sstb),   32'(vq[i].e_stb));
      chk($sformatf("v%0d_swe", i),  32'(swe),    32'(vq[i].e_we));
      chk($sformatf("v%0d_sadr", i), 32'(sadr),   32'(vq[i].e_adr));
      chk($sformatf("v%0d_sdat", i), 32'(sdat_o), 32'(vq[i].e_dat));
      chk($sformatf("v%0d_mack", i), 32'(mack),   32'(vq[i].e_ack));
      chk($sformatf("v%0d_mdat", i), 32'(mdat),   32'(vq[i].sd));
      chk($sformatf("v%0d_merr", i), 32'(merr),   32'h0);
      tick;
    end

    // reset while m0 is strobing drops the grant at that edge
    we = '0; wdat = '0; sdat_i = '0; adr = 32'h0000_0100;
    drive(2'b01, 2'b01, 1'b0);
    tick;
    chk("rstmid_pre_gnt", 32'(gnt), 32'h1);
    chk("rstmid_pre_sstb", 32'(sstb), 32'h1);
    rst = 1'b1;
    tick;
    chk("rstmid_gnt", 32'(gnt), 32'h0);
    chk("rstmid_scyc", 32'(scyc), 32'h0);
    rst = 1'b0;
    drive(2'b00, 2'b00, 1'b1);
    #1;
    chk("rstmid_stray_ack0", 32'(mack), 32'h0);
    tick;
    chk("rstmid_stray_ack1", 32'(mack), 32'h0);
    chk("rstmid_idle_gnt", 32'(gnt), 32'h0);
    sack = 1'b0;
    tick;

    // slave never acks
    adr = 32'h0000_0200;
    drive(2'b01, 2'b01, 1'b0);
    tick;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tmo_c%0d_gnt", k), 32'(gnt), 32'h1);
      chk($sformatf("tmo_c%0d_err", k), 32'(merr), 32'h0);
      tick;
    end
`ifdef LP805X_XBUS_TMO_EN
    chk("tmo_hit_gnt", 32'(gnt), 32'h0);
    chk("tmo_hit_err", 32'(merr), 32'h1);
    tick;
    chk("tmo_after_err", 32'(merr), 32'h0);
    chk("tmo_locked_gnt", 32'(gnt), 32'h0);
    drive(2'b00, 2'b00, 1'b0);
    tick;
    chk("tmo_drop_gnt", 32'(gnt), 32'h0);
    drive(2'b01, 2'b01, 1'b0);
    tick;
    chk("tmo_rearb_gnt", 32'(gnt), 32'h1);
`else
    for (int k = 9; k <= 12; k++) begin
      chk($sformatf("hold_c%0d_gnt", k), 32'(gnt), 32'h1);
      chk($sformatf("hold_c%0d_err", k), 32'(merr), 32'h0);
      tick;
    end
`endif
    drive(2'b00, 2'b00, 1'b0);
    tick;
    tick;
    chk("end_idle_gnt", 32'(gnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
